// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings,
// the S1 payload layout and the branch offset shift.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_DP_ROT = 2'b00,
        IMM_LS12   = 2'b01,
        IMM_BR     = 2'b10,
        IMM_HALF   = 2'b11
    } imm_mode_e;

    localparam int BR_SHIFT = 2;

    // The tag travels beside this payload because its width is a module parameter.
    typedef struct packed {
        imm_mode_e   mode;
        logic [23:0] imm;
        logic        carry;
    } s1_payload_t;

endpackage

// File: rtl/imm_rotator.sv
// Combinational rotator: imm8 rotated right by 2*rot4 within 32 bits,
// plus the bit that becomes the shifter carry-out.
module imm_rotator (
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot4,
    output logic [31:0] rot_val,
    output logic        carry_o
);

    logic [31:0] base;
    logic [4:0]  amt;

    assign base = {24'd0, imm8};
    assign amt  = {rot4, 1'b0};
    // A left shift by 32 yields zero, so amt == 0 needs no special case.
    assign rot_val = (base >> amt) | (base << (6'd32 - {1'b0, amt}));
    assign carry_o = rot_val[31];

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension pipeline (S1 raw fields, S2 extended result).
// Define IMM_ROT_EN to enable the mode-00 rotate and shifter carry-out.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       instr_imm,
    input  logic [1:0]        imm_src,
    input  logic              carry_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              shifter_carry,
    output logic [TAG_W-1:0]  tag_out
);

    // Handshake: a beat moves on valid && ready at the rising edge; the
    // producer never waits for ready before raising valid, and ready never
    // depends on the same-side valid.
    logic              s1_valid_q, s1_valid_d;
    s1_payload_t       s1_q, s1_d;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_q, ext_d;
    logic              carry_q, carry_d;
    logic [TAG_W-1:0]  tag_q;
    logic              s1_adv;
    logic              accept;

    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !reset && !flush && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;

    assign s1_d.mode  = imm_mode_e'(imm_src);
    assign s1_d.imm   = instr_imm;
    assign s1_d.carry = carry_in;

`ifdef IMM_ROT_EN
    logic [31:0] rot_val;
    logic        rot_carry;

    imm_rotator u_rot (
        .imm8    (s1_q.imm[7:0]),
        .rot4    (s1_q.imm[11:8]),
        .rot_val (rot_val),
        .carry_o (rot_carry)
    );
`endif

    always_comb begin
        ext_d   = '0;
        carry_d = s1_q.carry;
        case (s1_q.mode)
            IMM_DP_ROT: begin
`ifdef IMM_ROT_EN
                ext_d = DATA_W'(rot_val);
                if (s1_q.imm[11:8] != 4'd0) carry_d = rot_carry;
`else
                ext_d = DATA_W'(s1_q.imm[7:0]);
`endif
            end
            IMM_LS12: ext_d = DATA_W'(s1_q.imm[11:0]);
            IMM_BR:   ext_d = {{(DATA_W-24-BR_SHIFT){s1_q.imm[23]}}, s1_q.imm, {BR_SHIFT{1'b0}}};
            IMM_HALF: ext_d = DATA_W'({s1_q.imm[11:8], s1_q.imm[3:0]});
        endcase
    end

    // Flush wins over everything; a result taken in the flush cycle is simply gone.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (accept)      s1_valid_d = 1'b1;
            else if (s1_adv) s1_valid_d = 1'b0;
            if (s1_adv)         out_valid_d = 1'b1;
            else if (out_ready) out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            ext_q       <= '0;
            carry_q     <= 1'b0;
            tag_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                s1_q     <= s1_d;
                s1_tag_q <= tag_in;
            end
            if (s1_adv) begin
                ext_q   <= ext_d;
                carry_q <= carry_d;
                tag_q   <= s1_tag_q;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign ext_imm       = ext_q;
    assign shifter_carry = carry_q;
    assign tag_out       = tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe; expectations follow IMM_ROT_EN when defined.
module tb_imm_extend_pipe;

    localparam int DW = 32;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   instr_imm;
    logic [1:0]    imm_src;
    logic          carry_in;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ext_imm;
    logic          shifter_carry;
    logic [TW-1:0] tag_out;

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q[$];

    imm_extend_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr_imm     (instr_imm),
        .imm_src       (imm_src),
        .carry_in      (carry_in),
        .tag_in        (tag_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ext_imm       (ext_imm),
        .shifter_carry (shifter_carry),
        .tag_out       (tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [1:0] m, input logic [23:0] im,
                              input logic c, input logic [TW-1:0] t);
        in_valid  = 1'b1;
        imm_src   = m;
        instr_imm = im;
        carry_in  = c;
        tag_in    = t;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        imm_src = 2'b00; instr_imm = '0; carry_in = 1'b0; tag_in = '0;
        tick; tick;
        checks++;
        if (out_valid !== 1'b0 || ext_imm !== '0 || shifter_carry !== 1'b0 ||
            tag_out !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b imm=%h c=%b tag=%h rdy=%b, expected all 0",
                     out_valid, ext_imm, shifter_carry, tag_out, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        tick;
    endtask

    task automatic test_modes;
        logic [1:0]  m  [7];
        logic [23:0] im [7];
        logic        ci [7];
        logic [63:0] ex [7];
        logic        ec [7];
        m[0] = 2'b00; im[0] = 24'h0004FF; ci[0] = 1'b0;
        m[1] = 2'b00; im[1] = 24'h0000AB; ci[1] = 1'b1; ex[1] = 64'hAB; ec[1] = 1'b1;
        m[2] = 2'b00; im[2] = 24'h000103; ci[2] = 1'b0;
`ifdef IMM_ROT_EN
        ex[0] = 64'hFF000000; ec[0] = 1'b1;
        ex[2] = 64'hC0000000; ec[2] = 1'b1;
`else
        ex[0] = 64'h000000FF; ec[0] = 1'b0;
        ex[2] = 64'h00000003; ec[2] = 1'b0;
`endif
        m[3] = 2'b10; im[3] = 24'hFFFFFE; ci[3] = 1'b1; ex[3] = 64'hFFFFFFFFFFFFFFF8; ec[3] = 1'b1;
        m[4] = 2'b10; im[4] = 24'h000010; ci[4] = 1'b0; ex[4] = 64'h40;  ec[4] = 1'b0;
        m[5] = 2'b01; im[5] = 24'h123ABC; ci[5] = 1'b1; ex[5] = 64'hABC; ec[5] = 1'b1;
        m[6] = 2'b11; im[6] = 24'hFFFAF5; ci[6] = 1'b0; ex[6] = 64'hA5;  ec[6] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_beat(m[i], im[i], ci[i], TW'(8'h20 + i));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mode_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick;
            in_valid = 1'b0;
            carry_in = ~ci[i];
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mode_early[%0d]: out_valid got %b expected 0", i, out_valid);
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || ext_imm !== ex[i][DW-1:0] || shifter_carry !== ec[i] ||
                tag_out !== TW'(8'h20 + i)) begin
                errors++;
                $display("FAIL mode_result[%0d]: got v=%b imm=%h c=%b tag=%h, expected v=1 imm=%h c=%b tag=%h",
                         i, out_valid, ext_imm, shifter_carry, tag_out, ex[i][DW-1:0], ec[i], TW'(8'h20 + i));
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) drive_beat(2'b01, 24'(12'h111 * (cyc + 1)), 1'b0, TW'(8'h30 + cyc));
            else in_valid = 1'b0;
            #1;
            if (cyc < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", cyc, in_ready);
                end
            end
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || tag_out !== TW'(8'h30 + cyc - 2) ||
                    ext_imm !== DW'(12'h111 * (cyc - 1))) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got v=%b tag=%h imm=%h, expected v=1 tag=%h imm=%h",
                             cyc, out_valid, tag_out, ext_imm, TW'(8'h30 + cyc - 2), DW'(12'h111 * (cyc - 1)));
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        int next_tag = 1;
        int got = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            if (next_tag <= 5) drive_beat(2'b01, 24'(next_tag), 1'b0, TW'(next_tag));
            else in_valid = 1'b0;
            out_ready = (cyc >= 6);
            #1;
            if (cyc >= 2 && cyc < 6) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== TW'(1) || ext_imm !== DW'(1)) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got rdy=%b v=%b tag=%h imm=%h, expected rdy=0 v=1 tag=01 imm=1",
                             cyc, in_ready, out_valid, tag_out, ext_imm);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(TW'(next_tag));
                next_tag++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_order: got tag=%h, expected no result", tag_out);
                end else begin
                    if (tag_out !== exp_q[0] || ext_imm !== DW'(exp_q[0])) begin
                        errors++;
                        $display("FAIL bp_order: got tag=%h imm=%h, expected tag=%h imm=%h",
                                 tag_out, ext_imm, exp_q[0], DW'(exp_q[0]));
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 5 || next_tag != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results %0d accepts, expected 5 and 5", got, next_tag - 1);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive_beat(2'b01, 24'h011, 1'b0, 8'h11);
        tick;
        drive_beat(2'b01, 24'h012, 1'b0, 8'h12);
        tick;
        drive_beat(2'b01, 24'h013, 1'b0, 8'h13);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: got rdy=%b v=%b, expected rdy=0 v=1", in_ready, out_valid);
        end
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_next: out_valid got %b expected 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost[%0d]: out_valid got %b tag=%h expected 0", i, out_valid, tag_out);
            end
        end
        drive_beat(2'b01, 24'h014, 1'b1, 8'h14);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept: in_ready got %b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_lat_early: out_valid got %b expected 0", out_valid);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1 || tag_out !== 8'h14 || ext_imm !== DW'(24'h014) || shifter_carry !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got v=%b tag=%h imm=%h c=%b, expected v=1 tag=14 imm=14 c=1",
                     out_valid, tag_out, ext_imm, shifter_carry);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive_beat(2'b01, 24'h0005A5, 1'b1, 8'h77);
        tick;
        drive_beat(2'b01, 24'h000123, 1'b1, 8'h78);
        tick;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || tag_out !== 8'h77 || ext_imm !== DW'(12'h5A5) || shifter_carry !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got v=%b tag=%h imm=%h c=%b, expected v=1 tag=77 imm=5a5 c=1",
                     out_valid, tag_out, ext_imm, shifter_carry);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ext_imm !== '0 || shifter_carry !== 1'b0 ||
            tag_out !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%b imm=%h c=%b tag=%h rdy=%b, expected all 0",
                     out_valid, ext_imm, shifter_carry, tag_out, in_ready);
        end
        tick; tick;
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_ghost[%0d]: out_valid got %b tag=%h expected 0", i, out_valid, tag_out);
            end
        end
    endtask

    initial begin
        test_reset;
        test_modes;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
